// File: rtl/rgb_pwm_driver.sv
// LED driver for the RGB colour decoder: synchronises and debounces the colour
// lines into a committed colour code, then PWM-dims the three LED pins.
module rgb_pwm_driver #(
    parameter int PWM_BITS      = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                r_in,
    input  logic                g_in,
    input  logic                b_in,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                enable,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic [2:0]          color_q,
    output logic                color_chg
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [2:0]          sync1_r;
    logic [2:0]          sync2_r;
    logic [2:0]          cand_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] duty_q_r;

    logic [2:0]          cand_s;
    logic [CNT_W-1:0]    cnt_s;
    logic [2:0]          color_s;
    logic                chg_s;
    logic                pwm_wrap_s;
    logic                pwm_on_s;
    logic [PWM_BITS-1:0] pwm_cnt_s;
    logic [PWM_BITS-1:0] duty_q_s;
    logic [2:0]          led_s;

    // Debounce filter: a new candidate restarts the count, a return to the
    // committed colour clears it, otherwise count up to the commit point.
    always_comb begin
        cand_s  = cand_r;
        cnt_s   = cnt_r;
        color_s = color_q;
        chg_s   = 1'b0;
        if (sync2_r != cand_r) begin
            cand_s = sync2_r;
            cnt_s  = {CNT_W{1'b0}};
        end else if (sync2_r == color_q) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            color_s = sync2_r;
            chg_s   = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            cnt_s = cnt_r + CNT_W'(1);
        end
    end

    // PWM period counter and duty latch; duty only reloads on the wrap edge
    // so an in-flight period is never reshaped.
    always_comb begin
        pwm_wrap_s = (pwm_cnt_r == PWM_LAST);
        pwm_on_s   = (pwm_cnt_r < duty_q_r);
        if (pwm_wrap_s) begin
            pwm_cnt_s = {PWM_BITS{1'b0}};
            duty_q_s  = duty;
        end else begin
            pwm_cnt_s = pwm_cnt_r + PWM_BITS'(1);
            duty_q_s  = duty_q_r;
        end
        if (enable && pwm_on_s) begin
            led_s = color_q;
        end else begin
            led_s = 3'b000;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r   <= 3'b000;
            sync2_r   <= 3'b000;
            cand_r    <= 3'b000;
            cnt_r     <= {CNT_W{1'b0}};
            color_q   <= 3'b000;
            color_chg <= 1'b0;
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            duty_q_r  <= {PWM_BITS{1'b0}};
            led_r     <= 1'b0;
            led_g     <= 1'b0;
            led_b     <= 1'b0;
        end else begin
            sync1_r   <= {r_in, g_in, b_in};
            sync2_r   <= sync1_r;
            cand_r    <= cand_s;
            cnt_r     <= cnt_s;
            color_q   <= color_s;
            color_chg <= chg_s;
            pwm_cnt_r <= pwm_cnt_s;
            duty_q_r  <= duty_q_s;
            led_r     <= led_s[2];
            led_g     <= led_s[1];
            led_b     <= led_s[0];
        end
    end

endmodule
